// File: rtl/tft_frame_sequencer.sv
// Frame-level sequencer for the PMOD TFT pixel path: window-setup words, then RGB565 pixels.
// Optional internal test-pattern source is enabled by defining TFT_TEST_PATTERN_EN.
module tft_frame_sequencer #(
    parameter logic [7:0] CMD_COL_ADDR  = 8'h2A,
    parameter logic [7:0] CMD_ROW_ADDR  = 8'h2B,
    parameter logic [7:0] CMD_MEM_WRITE = 8'h2C
) (
`ifdef TFT_TEST_PATTERN_EN
    input  logic        i_pattern,
`endif
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_width,
    input  logic [15:0] i_height,
    input  logic        i_pixel_rdy,
    output logic        o_pixel_stb,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic        i_tft_busy,
    output logic        o_tft_stb,
    output logic        o_tft_cmd,
    output logic [15:0] o_tft_data,
    output logic        o_busy,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic [15:0] o_frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STREAM,
        DONE
    } state_t;

    localparam logic [3:0] LAST_SETUP_IDX = 4'd10;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [15:0] w_q;
    logic [15:0] h_q;
    logic        pix_stb_q;
    logic        frame_start_q;
    logic [15:0] frame_count_q;

    logic [15:0] w_m1;
    logic [15:0] h_m1;
    logic        x_end;
    logic        last_px;
    logic        start_ok;
    logic        start_frame;
    logic        pattern_mode;
    logic [16:0] setup_out;
    logic [15:0] reader_px;
    logic [15:0] pattern_px;
    logic [7:0]  pattern_b;
    logic        unused_lsbs;

    function automatic logic [15:0] pack_rgb565(input logic [4:0] r5,
                                                input logic [5:0] g6,
                                                input logic [4:0] b5);
        return {r5, g6, b5};
    endfunction

    // {cmd flag, word} for each position of the window-setup sequence
    function automatic logic [16:0] setup_word(input logic [3:0]  idx,
                                               input logic [15:0] wm1,
                                               input logic [15:0] hm1);
        case (idx)
            4'd0:    return {1'b1, 8'h00, CMD_COL_ADDR};
            4'd3:    return {1'b0, 8'h00, wm1[15:8]};
            4'd4:    return {1'b0, 8'h00, wm1[7:0]};
            4'd5:    return {1'b1, 8'h00, CMD_ROW_ADDR};
            4'd8:    return {1'b0, 8'h00, hm1[15:8]};
            4'd9:    return {1'b0, 8'h00, hm1[7:0]};
            4'd10:   return {1'b1, 8'h00, CMD_MEM_WRITE};
            default: return 17'h0_0000;
        endcase
    endfunction

    assign w_m1        = w_q - 16'd1;
    assign h_m1        = h_q - 16'd1;
    assign x_end       = (x_q == w_m1);
    assign last_px     = x_end && (y_q == h_m1);
    assign start_ok    = i_enable && (i_width != 16'd0) && (i_height != 16'd0);
    assign start_frame = start_ok && ((state_q == IDLE) || (state_q == DONE));
    assign setup_out   = setup_word(idx_q, w_m1, h_m1);
    assign reader_px   = pack_rgb565(i_red[7:3], i_green[7:2], i_blue[7:3]);
    assign pattern_b   = x_q[7:0] ^ y_q[7:0];
    assign pattern_px  = pack_rgb565(x_q[7:3], y_q[7:2], pattern_b[7:3]);
    assign unused_lsbs = ^{i_red[2:0], i_green[1:0], i_blue[2:0], pattern_b[2:0], y_q[1:0], x_q[2:0]};

    assign o_busy        = (state_q != IDLE);
    assign o_frame_start = frame_start_q;
    assign o_frame_count = frame_count_q;

    // Strobes are gated by the current busy/rdy so a word is never offered to a busy writer
    always_comb begin
        o_tft_stb    = 1'b0;
        o_tft_cmd    = 1'b0;
        o_tft_data   = 16'h0000;
        o_pixel_stb  = 1'b0;
        o_frame_done = 1'b0;
        case (state_q)
            SETUP: begin
                if (!i_tft_busy) begin
                    o_tft_stb  = 1'b1;
                    o_tft_cmd  = setup_out[16];
                    o_tft_data = setup_out[15:0];
                end
            end
            STREAM: begin
                if (pattern_mode) begin
                    if (!i_tft_busy) begin
                        o_tft_stb    = 1'b1;
                        o_tft_data   = pattern_px;
                        o_frame_done = last_px;
                    end
                end else if (i_pixel_rdy && !i_tft_busy && !pix_stb_q) begin
                    o_pixel_stb  = 1'b1;
                    o_tft_stb    = 1'b1;
                    o_tft_data   = reader_px;
                    o_frame_done = last_px;
                end
            end
            default: ;
        endcase
    end

`ifdef TFT_TEST_PATTERN_EN
    logic pattern_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= 1'b0;
        end else if (start_frame) begin
            pattern_q <= i_pattern;
        end
    end

    assign pattern_mode = pattern_q;
`else
    assign pattern_mode = 1'b0;
`endif

    // Frame geometry is data: captured at frame start, only read outside IDLE
    always_ff @(posedge clk) begin
        if (start_frame) begin
            w_q <= i_width;
            h_q <= i_height;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            pix_stb_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            pix_stb_q     <= o_pixel_stb;
            frame_start_q <= start_frame;
            case (state_q)
                IDLE: begin
                    if (start_frame) begin
                        state_q <= SETUP;
                        idx_q   <= 4'd0;
                        x_q     <= 16'd0;
                        y_q     <= 16'd0;
                    end
                end
                SETUP: begin
                    if (!i_tft_busy) begin
                        if (idx_q == LAST_SETUP_IDX) begin
                            state_q <= STREAM;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                STREAM: begin
                    if (o_tft_stb) begin
                        if (last_px) begin
                            state_q       <= DONE;
                            x_q           <= 16'd0;
                            y_q           <= 16'd0;
                            frame_count_q <= frame_count_q + 16'd1;
                        end else if (x_end) begin
                            x_q <= 16'd0;
                            y_q <= y_q + 16'd1;
                        end else begin
                            x_q <= x_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (start_frame) begin
                        state_q <= SETUP;
                        idx_q   <= 4'd0;
                        x_q     <= 16'd0;
                        y_q     <= 16'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// Directed bench for tft_frame_sequencer: setup words, pixel packing, busy, enable, reset, sizes.
module tb_tft_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_enable;
    logic [15:0] i_width;
    logic [15:0] i_height;
    logic        i_pixel_rdy;
    logic        o_pixel_stb;
    logic [7:0]  i_red;
    logic [7:0]  i_green;
    logic [7:0]  i_blue;
    logic        i_tft_busy;
    logic        o_tft_stb;
    logic        o_tft_cmd;
    logic [15:0] o_tft_data;
    logic        o_busy;
    logic        o_frame_start;
    logic        o_frame_done;
    logic [15:0] o_frame_count;
`ifdef TFT_TEST_PATTERN_EN
    logic        i_pattern;
`endif

    tft_frame_sequencer dut (
`ifdef TFT_TEST_PATTERN_EN
        .i_pattern    (i_pattern),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_width      (i_width),
        .i_height     (i_height),
        .i_pixel_rdy  (i_pixel_rdy),
        .o_pixel_stb  (o_pixel_stb),
        .i_red        (i_red),
        .i_green      (i_green),
        .i_blue       (i_blue),
        .i_tft_busy   (i_tft_busy),
        .o_tft_stb    (o_tft_stb),
        .o_tft_cmd    (o_tft_cmd),
        .o_tft_data   (o_tft_data),
        .o_busy       (o_busy),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_frame_count(o_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        wcmd[$];
    logic [15:0] wdata[$];
    int          wcyc[$];
    int          cyc = 0;
    int          pix_cnt = 0;
    int          done_cnt = 0;
    int          start_cnt = 0;
    int          busy_viol = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_tft_stb) begin
            wcmd.push_back(o_tft_cmd);
            wdata.push_back(o_tft_data);
            wcyc.push_back(cyc);
        end
        if (o_tft_stb && i_tft_busy) busy_viol = busy_viol + 1;
        if (o_pixel_stb) pix_cnt = pix_cnt + 1;
        if (o_frame_done) done_cnt = done_cnt + 1;
        if (o_frame_start) start_cnt = start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wcmd.delete();
        wdata.delete();
        wcyc.delete();
        pix_cnt   = 0;
        done_cnt  = 0;
        start_cnt = 0;
        busy_viol = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pix(input string tag, input int n, input int limit);
        int c = 0;
        while (pix_cnt < n && c < limit) begin
            @(posedge clk); #1;
            @(negedge clk); #1;
            c++;
        end
        chk({tag, "_pix_reached"}, 32'(pix_cnt >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int n, input int limit, input bit rnd_busy);
        int c = 0;
        while (done_cnt < n && c < limit) begin
            @(posedge clk); #1;
            if (rnd_busy) i_tft_busy = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            c++;
        end
        i_tft_busy = 1'b0;
        chk({tag, "_done_reached"}, 32'(done_cnt), 32'(n));
    endtask

    function automatic logic [16:0] exp_setup(input int i, input logic [15:0] w, input logic [15:0] h);
        logic [15:0] wm;
        logic [15:0] hm;
        wm = w - 16'd1;
        hm = h - 16'd1;
        case (i)
            0:       return {1'b1, 16'h002A};
            3:       return {1'b0, 8'h00, wm[15:8]};
            4:       return {1'b0, 8'h00, wm[7:0]};
            5:       return {1'b1, 16'h002B};
            8:       return {1'b0, 8'h00, hm[15:8]};
            9:       return {1'b0, 8'h00, hm[7:0]};
            10:      return {1'b1, 16'h002C};
            default: return 17'h0_0000;
        endcase
    endfunction

    task automatic check_frame(input string tag, input logic [15:0] w, input logic [15:0] h,
                               input logic [15:0] pix, input int npix, input bit gaps);
        logic [16:0] e;
        chk({tag, "_nwords"}, 32'(wcmd.size()), 32'(11 + npix));
        if (wcmd.size() == 11 + npix) begin
            for (int i = 0; i < 11; i++) begin
                e = exp_setup(i, w, h);
                chk($sformatf("%s_setup%0d_cmd", tag, i), 32'(wcmd[i]), 32'(e[16]));
                chk($sformatf("%s_setup%0d_data", tag, i), 32'(wdata[i]), 32'(e[15:0]));
            end
            for (int i = 11; i < 11 + npix; i++) begin
                chk($sformatf("%s_pix%0d_cmd", tag, i - 11), 32'(wcmd[i]), 32'd0);
                chk($sformatf("%s_pix%0d_data", tag, i - 11), 32'(wdata[i]), 32'(pix));
            end
            if (gaps) begin
                for (int i = 0; i < 10 + npix; i++)
                    chk($sformatf("%s_gap%0d", tag, i), 32'(wcyc[i + 1] - wcyc[i]),
                        (i < 11) ? 32'd1 : 32'd2);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_enable    = 1'b0;
        i_width     = 16'd0;
        i_height    = 16'd0;
        i_pixel_rdy = 1'b0;
        i_red       = 8'h00;
        i_green     = 8'h00;
        i_blue      = 8'h00;
        i_tft_busy  = 1'b0;
`ifdef TFT_TEST_PATTERN_EN
        i_pattern   = 1'b0;
`endif
        step(3);
        @(negedge clk); #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_tft_stb", 32'(o_tft_stb), 32'd0);
        chk("rst_pixel_stb", 32'(o_pixel_stb), 32'd0);
        chk("rst_frame_count", 32'(o_frame_count), 32'd0);
        chk("rst_tft_data", 32'(o_tft_data), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // 2x2 frame, writer always ready, reader always ready
        clear_log();
        i_width = 16'd2; i_height = 16'd2;
        i_red = 8'h80; i_green = 8'h40; i_blue = 8'h20;
        i_pixel_rdy = 1'b1;
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
        wait_done("t1", 1, 100, 1'b0);
        step(3);
        check_frame("t1", 16'd2, 16'd2, 16'h8204, 4, 1'b1);
        chk("t1_pix_cnt", 32'(pix_cnt), 32'd4);
        chk("t1_start_cnt", 32'(start_cnt), 32'd1);
        chk("t1_frame_count", 32'(o_frame_count), 32'd1);
        chk("t1_busy_end", 32'(o_busy), 32'd0);

        // RGB565 packing of two distinct pixels
        clear_log();
        i_width = 16'd2; i_height = 16'd1;
        i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
        wait_pix("t2a", 1, 50);
        chk("t2_px0", 32'(o_tft_data), 32'h0000_FFFF);
        step(1);
        i_red = 8'h08; i_green = 8'h04; i_blue = 8'h08;
        wait_pix("t2b", 2, 50);
        chk("t2_px1", 32'(o_tft_data), 32'h0000_0821);
        wait_done("t2", 1, 50, 1'b0);
        step(3);
        chk("t2_frame_count", 32'(o_frame_count), 32'd2);

        // random writer back-pressure: identical word stream, no strobe while busy
        clear_log();
        i_width = 16'd2; i_height = 16'd2;
        i_red = 8'h80; i_green = 8'h40; i_blue = 8'h20;
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
        wait_done("t3", 1, 600, 1'b1);
        step(3);
        check_frame("t3", 16'd2, 16'd2, 16'h8204, 4, 1'b0);
        chk("t3_busy_viol", 32'(busy_viol), 32'd0);
        chk("t3_frame_count", 32'(o_frame_count), 32'd3);

        // enable dropped and geometry changed after the first pixel: frame still completes
        clear_log();
        i_enable = 1'b1;
        wait_pix("t4", 1, 50);
        step(1);
        i_enable = 1'b0;
        i_width = 16'd5; i_height = 16'd7;
        wait_done("t4", 1, 50, 1'b0);
        step(3);
        check_frame("t4", 16'd2, 16'd2, 16'h8204, 4, 1'b1);
        chk("t4_pix_cnt", 32'(pix_cnt), 32'd4);
        chk("t4_start_cnt", 32'(start_cnt), 32'd1);
        chk("t4_busy_end", 32'(o_busy), 32'd0);
        chk("t4_frame_count", 32'(o_frame_count), 32'd4);

        // 1x1 frame: done coincides with the single pixel
        clear_log();
        i_width = 16'd1; i_height = 16'd1;
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
        wait_pix("t5", 1, 50);
        chk("t5_done_with_pix", 32'(o_frame_done), 32'd1);
        step(3);
        check_frame("t5", 16'd1, 16'd1, 16'h8204, 1, 1'b1);
        chk("t5_frame_count", 32'(o_frame_count), 32'd5);

        // zero width never starts
        clear_log();
        i_width = 16'd0; i_height = 16'd5;
        i_enable = 1'b1;
        step(20);
        @(negedge clk); #1;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_nwords", 32'(wcmd.size()), 32'd0);
        chk("t6_pix_cnt", 32'(pix_cnt), 32'd0);

        // reset in the middle of streaming
        step(1);
        i_width = 16'd2; i_height = 16'd2;
        wait_pix("t7", 1, 50);
        rst_n = 1'b0;
        #1;
        chk("t7_busy", 32'(o_busy), 32'd0);
        chk("t7_tft_stb", 32'(o_tft_stb), 32'd0);
        chk("t7_pixel_stb", 32'(o_pixel_stb), 32'd0);
        chk("t7_tft_data", 32'(o_tft_data), 32'd0);
        chk("t7_frame_done", 32'(o_frame_done), 32'd0);
        chk("t7_frame_count", 32'(o_frame_count), 32'd0);
        step(1);
        i_enable = 1'b0;
        rst_n = 1'b1;
        step(3);
        chk("t7_busy_after", 32'(o_busy), 32'd0);

`ifdef TFT_TEST_PATTERN_EN
        // internal pattern, 4x2, reader ignored
        clear_log();
        i_width = 16'd4; i_height = 16'd2;
        i_pattern = 1'b1;
        i_enable = 1'b1;
        step(1);
        i_enable = 1'b0;
        i_pattern = 1'b0;
        wait_done("t8", 1, 100, 1'b0);
        step(3);
        chk("t8_nwords", 32'(wcmd.size()), 32'd19);
        chk("t8_pix_cnt", 32'(pix_cnt), 32'd0);
        if (wcmd.size() == 19) begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] px;
                logic [7:0] py;
                logic [7:0] pb;
                px = 8'(i % 4);
                py = 8'(i / 4);
                pb = px ^ py;
                chk($sformatf("t8_pix%0d", i), 32'(wdata[11 + i]), 32'({px[7:3], py[7:2], pb[7:3]}));
                if (i > 0) chk($sformatf("t8_gap%0d", i), 32'(wcyc[11 + i] - wcyc[10 + i]), 32'd1);
            end
            chk("t8_last", 32'(wdata[18]), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
